// File: rtl/cpu_pkg.sv
// Shared CPU definitions: sequencer state encoding, opcode values and default widths.
// Optional feature macro: PC_SEQUENCER_STEP_EN adds the PAUSE state used for single-stepping.
package cpu_pkg;

    localparam int unsigned PC_W_DEF = 3;
    localparam int unsigned OP_W_DEF = 3;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_ALU  = 3'b001;
    localparam logic [2:0] OP_LOAD = 3'b010;
    localparam logic [2:0] OP_JMP  = 3'b100;
    localparam logic [2:0] OP_BEQZ = 3'b101;
    localparam logic [2:0] OP_HALT = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_WRITEBACK = 3'd4,
        S_HALT      = 3'd5
`ifdef PC_SEQUENCER_STEP_EN
        , S_PAUSE   = 3'd6
`endif
    } state_e;

endpackage

// File: rtl/pc_sequencer.sv
// pc_sequencer: instruction sequencing FSM plus next-PC selection for a small CPU.
// The PC register itself lives in program_counter; this block only presents pc_next/pc_we.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start           pulse that leaves IDLE
//   imem_ready      instruction data valid for pc_cur
//   opcode, target  fields of the fetched instruction (captured on fetch)
//   zero            ALU zero flag, sampled in EXECUTE
//   step            single-step advance (only with PC_SEQUENCER_STEP_EN)
//   pc_cur          current PC value
//   pc_next, pc_we  next PC and its one-cycle load enable
//   ir_load, alu_en, reg_we, halted   registered control strobes
// Macro PC_SEQUENCER_STEP_EN: adds the step port and a PAUSE state after WRITEBACK.
module pc_sequencer
    import cpu_pkg::*;
#(
    parameter int unsigned PC_W = PC_W_DEF,
    parameter int unsigned OP_W = OP_W_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            imem_ready,
    input  logic [OP_W-1:0] opcode,
    input  logic [PC_W-1:0] target,
    input  logic            zero,
`ifdef PC_SEQUENCER_STEP_EN
    input  logic            step,
`endif
    input  logic [PC_W-1:0] pc_cur,
    output logic [PC_W-1:0] pc_next,
    output logic            pc_we,
    output logic            ir_load,
    output logic            alu_en,
    output logic            reg_we,
    output logic            halted
);

    state_e          r_state, w_state_nxt;
    logic [OP_W-1:0] r_op, w_op_nxt;
    logic [PC_W-1:0] r_tgt, w_tgt_nxt;
    logic            r_zero;
    logic [PC_W-1:0] r_pc_next, w_pc_next_nxt;
    logic            r_pc_we, w_pc_we_nxt;
    logic            r_ir_load, w_ir_load_nxt;
    logic            r_alu_en, w_alu_en_nxt;
    logic            r_reg_we, w_reg_we_nxt;
    logic            r_halted, w_halted_nxt;

    logic            w_writes;
    logic            w_zero_smp;
    logic            w_taken;
    logic [PC_W-1:0] w_pc_inc;

    // Only ALU and LOAD produce a register result.
    assign w_writes   = (r_op == OP_W'(OP_ALU)) || (r_op == OP_W'(OP_LOAD));
    // Zero flag as seen during EXECUTE; the live input is used on the EXECUTE edge itself.
    assign w_zero_smp = (r_state == S_EXECUTE) ? zero : r_zero;
    assign w_taken    = (r_op == OP_W'(OP_JMP)) ||
                        ((r_op == OP_W'(OP_BEQZ)) && w_zero_smp);
    // Natural wrap at 2^PC_W.
    assign w_pc_inc   = pc_cur + PC_W'(1);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and next values of the registered outputs.
    always_comb begin
        w_state_nxt   = r_state;
        w_op_nxt      = r_op;
        w_tgt_nxt     = r_tgt;
        w_pc_next_nxt = r_pc_next;
        w_pc_we_nxt   = 1'b0;
        w_ir_load_nxt = 1'b0;
        w_alu_en_nxt  = 1'b0;
        w_reg_we_nxt  = 1'b0;
        w_halted_nxt  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                if (imem_ready) begin
                    w_state_nxt   = S_DECODE;
                    w_ir_load_nxt = 1'b1;
                    w_op_nxt      = opcode;
                    w_tgt_nxt     = target;
                end
            end
            S_DECODE: begin
                if (r_op == OP_W'(OP_HALT)) begin
                    w_state_nxt  = S_HALT;
                    w_halted_nxt = 1'b1;
                end else begin
                    w_state_nxt  = S_EXECUTE;
                    w_alu_en_nxt = w_writes;
                end
            end
            S_EXECUTE: begin
                w_state_nxt   = S_WRITEBACK;
                w_pc_we_nxt   = 1'b1;
                w_reg_we_nxt  = w_writes;
                w_pc_next_nxt = w_taken ? r_tgt : w_pc_inc;
            end
            S_WRITEBACK: begin
`ifdef PC_SEQUENCER_STEP_EN
                w_state_nxt = S_PAUSE;
`else
                w_state_nxt = S_FETCH;
`endif
            end
`ifdef PC_SEQUENCER_STEP_EN
            S_PAUSE: begin
                if (step) begin
                    w_state_nxt = S_FETCH;
                end
            end
`endif
            S_HALT: begin
                w_halted_nxt = 1'b1;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Instruction fields, sampled zero flag and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op      <= '0;
            r_tgt     <= '0;
            r_zero    <= 1'b0;
            r_pc_next <= '0;
            r_pc_we   <= 1'b0;
            r_ir_load <= 1'b0;
            r_alu_en  <= 1'b0;
            r_reg_we  <= 1'b0;
            r_halted  <= 1'b0;
        end else begin
            r_op      <= w_op_nxt;
            r_tgt     <= w_tgt_nxt;
            if (r_state == S_EXECUTE) begin
                r_zero <= zero;
            end
            r_pc_next <= w_pc_next_nxt;
            r_pc_we   <= w_pc_we_nxt;
            r_ir_load <= w_ir_load_nxt;
            r_alu_en  <= w_alu_en_nxt;
            r_reg_we  <= w_reg_we_nxt;
            r_halted  <= w_halted_nxt;
        end
    end

    assign pc_next = r_pc_next;
    assign pc_we   = r_pc_we;
    assign ir_load = r_ir_load;
    assign alu_en  = r_alu_en;
    assign reg_we  = r_reg_we;
    assign halted  = r_halted;

endmodule
